fft_sdf_bf_st3: RTL

//  Radix-2 DIF single-path-delay-feedback butterfly for FFT stage 3. It drives the stage-3 twiddle ROM
//  (tw_mem_st3: 1-bit addr, Q1.11 twiddles, 1-cycle registered read) and multiplies the butterfly

---
 rtl/fft_pkg.sv | 27 ++
 rtl/fft_cmul.sv | 69 ++++++
 rtl/fft_sdf_bf_st3.sv | 84 ++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: widths, complex sample types and output saturation shared by the SDF butterfly stages.
package fft_pkg;
  localparam int DW      = 12;
  localparam int TW      = 12;
  localparam int TW_FRAC = TW - 1;
  localparam int DELAY   = 2;
  localparam int AW      = $clog2(DELAY);
  localparam int CW      = $clog2(2 * DELAY);
  localparam int PW      = DW + TW + 2;

  typedef struct packed {
    logic signed [DW:0] re;
    logic signed [DW:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [TW-1:0] re;
    logic signed [TW-1:0] im;
  } tw_t;

  // Clamp a shifted product to the DW+1 bit output range.
  function automatic logic signed [DW:0] sat(input logic signed [PW-1:0] v);
    if ((&v[PW-1:DW]) || (~|v[PW-1:DW])) return v[DW:0];
    else if (v[PW-1]) return {1'b1, {DW{1'b0}}};
    else return {1'b0, {DW{1'b1}}};
  endfunction
endpackage

// File: rtl/fft_cmul.sv
// fft_cmul: two-stage complex multiply by a Q1.(TW-1) twiddle, with an exact unity bypass.
// FFT_ROUND_EN: when defined, round half up before the fractional shift; otherwise truncate.
module fft_cmul
  import fft_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  input  logic  sel_tw,
  input  cplx_t din,
  input  tw_t   tw,
  output logic  out_valid,
  output cplx_t dout
);
`ifdef FFT_ROUND_EN
  localparam logic signed [PW-1:0] RND = PW'(1) << (TW_FRAC - 1);
`else
  localparam logic signed [PW-1:0] RND = '0;
`endif

  logic signed [DW:0]   a_re, a_im;
  logic signed [TW-1:0] t_re, t_im;
  logic signed [PW-1:0] m_re, m_im;
  logic signed [PW-1:0] s_re, s_im;

  logic                 a_valid, a_sel;
  logic signed [PW-1:0] a_mre, a_mim;
  cplx_t                a_byp;

  always_comb begin
    a_re = din.re;
    a_im = din.im;
    t_re = tw.re;
    t_im = tw.im;
    m_re = PW'(a_re) * PW'(t_re) - PW'(a_im) * PW'(t_im);
    m_im = PW'(a_re) * PW'(t_im) + PW'(a_im) * PW'(t_re);
  end

  assign s_re = (a_mre + RND) >>> TW_FRAC;
  assign s_im = (a_mim + RND) >>> TW_FRAC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid   <= 1'b0;
      a_sel     <= 1'b0;
      a_mre     <= '0;
      a_mim     <= '0;
      a_byp     <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
    end else begin
      a_valid   <= in_valid;
      a_sel     <= sel_tw;
      a_mre     <= m_re;
      a_mim     <= m_im;
      a_byp     <= din;
      out_valid <= a_valid;
      // Output holds its last sample while nothing new arrives.
      if (a_valid) begin
        if (a_sel) begin
          dout.re <= sat(s_re);
          dout.im <= sat(s_im);
        end else begin
          dout <= a_byp;
        end
      end
    end
  end
endmodule

// File: rtl/fft_sdf_bf_st3.sv
// fft_sdf_bf_st3: radix-2 DIF single-path delay-feedback butterfly, FFT stage 3, twiddle ROM driver.
// Rounding of the twiddle product is selected by FFT_ROUND_EN (see fft_cmul).
module fft_sdf_bf_st3
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic [AW-1:0]        tw_addr,
  input  logic signed [TW-1:0] tw_re,
  input  logic signed [TW-1:0] tw_im,
  output logic                 out_valid,
  output logic signed [DW:0]   out_re,
  output logic signed [DW:0]   out_im
);
  logic [CW-1:0] cnt;
  logic          primed;
  logic          phase;
  cplx_t         dl [DELAY];
  cplx_t         x, head, bf, dl_in;
  logic          p1_valid, p1_sel;
  cplx_t         p1_d;
  tw_t           tw_in;
  cplx_t         res;

  assign phase   = cnt[CW-1];
  assign tw_addr = cnt[AW-1:0];
  assign head    = dl[DELAY-1];

  // Fill phase parks x and emits the previous frame's difference; butterfly phase forms sum/difference.
  always_comb begin
    x.re  = {in_re[DW-1], in_re};
    x.im  = {in_im[DW-1], in_im};
    bf    = head;
    dl_in = x;
    if (phase) begin
      bf.re    = head.re + x.re;
      bf.im    = head.im + x.im;
      dl_in.re = head.re - x.re;
      dl_in.im = head.im - x.im;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      primed   <= 1'b0;
      p1_valid <= 1'b0;
      p1_sel   <= 1'b0;
      p1_d     <= '0;
      for (int i = 0; i < DELAY; i++) dl[i] <= '0;
    end else begin
      p1_valid <= in_valid && (phase || primed);
      if (in_valid) begin
        cnt    <= (cnt == CW'(2 * DELAY - 1)) ? '0 : cnt + 1'b1;
        p1_d   <= bf;
        p1_sel <= !phase;
        if (phase) primed <= 1'b1;
        dl[0] <= dl_in;
        for (int i = 1; i < DELAY; i++) dl[i] <= dl[i-1];
      end
    end
  end

  // ROM data for the P1 sample arrives one cycle after tw_addr, alongside P1.
  assign tw_in.re = tw_re;
  assign tw_in.im = tw_im;

  fft_cmul u_cmul (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (p1_valid),
    .sel_tw    (p1_sel),
    .din       (p1_d),
    .tw        (tw_in),
    .out_valid (out_valid),
    .dout      (res)
  );

  assign out_re = res.re;
  assign out_im = res.im;
endmodule
